// File: rtl/match_comparator.sv
// match_comparator: tracks the minimum SAD score and its raster (x, y) position over a search window.
// Define MATCH_COMPARATOR_SECOND_BEST_EN to add second_sad tracking and an ambiguity margin on match.
module match_comparator #(
   parameter int          COLS   = 64,
   parameter int          ROWS   = 48,
   parameter int          COL_W  = 8,
   parameter int          ROW_W  = 8,
   parameter logic [11:0] THRESH = 12'd400
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ena,
   input  logic [11:0]      d_in,
   output logic             busy,
   output logic             done,
   output logic [11:0]      best_sad,
   output logic [COL_W-1:0] best_x,
   output logic [ROW_W-1:0] best_y,
   output logic             match
`ifdef MATCH_COMPARATOR_SECOND_BEST_EN
   ,
   output logic [11:0]      second_sad
`endif
);

   localparam logic [COL_W-1:0] X_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] Y_LAST = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [COL_W-1:0] x_cnt;
   logic [ROW_W-1:0] y_cnt;
   logic             s1_valid;
   logic [11:0]      s1_sad;
   logic [COL_W-1:0] s1_x;
   logic [ROW_W-1:0] s1_y;
   logic             accept;
   logic             last_sample;
   logic             s2_load;
   logic [11:0]      best_sad_nxt;
   logic             match_nxt;

   // start has priority over ena, so a sample presented alongside start is dropped
   assign accept       = (state == SCAN) && ena && !start;
   assign last_sample  = accept && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
   assign s2_load      = s1_valid && (s1_sad < best_sad);
   assign best_sad_nxt = s2_load ? s1_sad : best_sad;
   assign busy         = (state == SCAN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = SCAN;
      end else begin
         case (state)
            SCAN:    if (last_sample) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   // Stage 1: capture the score together with its raster position
   always_ff @(posedge clk) begin
      if (rst || start) begin
         x_cnt    <= '0;
         y_cnt    <= '0;
         s1_valid <= 1'b0;
         s1_sad   <= '0;
         s1_x     <= '0;
         s1_y     <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_sad <= d_in;
            s1_x   <= x_cnt;
            s1_y   <= y_cnt;
            if (x_cnt == X_LAST) begin
               x_cnt <= '0;
               y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + ROW_W'(1);
            end else begin
               x_cnt <= x_cnt + COL_W'(1);
            end
         end
      end
   end

`ifdef MATCH_COMPARATOR_SECOND_BEST_EN
   localparam logic [11:0] MARGIN = 12'd16;

   logic [11:0] second_nxt;

   // A displaced best becomes the runner-up; otherwise a lower score replaces it
   always_comb begin
      second_nxt = second_sad;
      if (s2_load) begin
         second_nxt = best_sad;
      end else if (s1_valid && (s1_sad < second_sad)) begin
         second_nxt = s1_sad;
      end
   end

   assign match_nxt = (best_sad_nxt <= THRESH) && ((second_nxt - best_sad_nxt) >= MARGIN);

   always_ff @(posedge clk) begin
      if (rst || start) begin
         second_sad <= 12'hFFF;
      end else begin
         second_sad <= second_nxt;
      end
   end
`else
   assign match_nxt = (best_sad_nxt <= THRESH);
`endif

   // Stage 2: strict less-than keeps the earliest raster position on ties;
   // match is judged from the post-update values as the last sample lands
   always_ff @(posedge clk) begin
      if (rst || start) begin
         best_sad <= 12'hFFF;
         best_x   <= '0;
         best_y   <= '0;
         match    <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= (state == FLUSH);
         if (s2_load) begin
            best_sad <= s1_sad;
            best_x   <= s1_x;
            best_y   <= s1_y;
         end
         if (state == FLUSH) begin
            match <= match_nxt;
         end
      end
   end

endmodule

// File: tb/tb_match_comparator.sv
// Testbench for match_comparator: directed and random search windows checked through a result scoreboard.
// Builds with or without MATCH_COMPARATOR_SECOND_BEST_EN.
module tb_match_comparator;

   localparam int          COLS   = 4;
   localparam int          ROWS   = 2;
   localparam int          COL_W  = 3;
   localparam int          ROW_W  = 2;
   localparam int          NPOS   = COLS * ROWS;
   localparam logic [11:0] THRESH = 12'd100;

   typedef struct {
      logic [11:0] sad;
      int          x;
      int          y;
      logic        m;
      logic [11:0] second;
      int          done_cyc;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic             ena;
   logic [11:0]      d_in;
   logic             busy;
   logic             done;
   logic [11:0]      best_sad;
   logic [COL_W-1:0] best_x;
   logic [ROW_W-1:0] best_y;
   logic             match;
`ifdef MATCH_COMPARATOR_SECOND_BEST_EN
   logic [11:0]      second_sad;
`endif

   exp_t        exp_q[$];
   logic [11:0] scores[NPOS];
   int          n_cmp;
   int          n_fail;
   int          cyc;
   int          dones_seen;
   int          dones_expected;
   int          last_n;
   logic [11:0] last_sad;
   logic        last_match;

   match_comparator #(
      .COLS   (COLS),
      .ROWS   (ROWS),
      .COL_W  (COL_W),
      .ROW_W  (ROW_W),
      .THRESH (THRESH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ena        (ena),
      .d_in       (d_in),
      .busy       (busy),
      .done       (done),
      .best_sad   (best_sad),
      .best_x     (best_x),
      .best_y     (best_y),
      .match      (match)
`ifdef MATCH_COMPARATOR_SECOND_BEST_EN
      ,
      .second_sad (second_sad)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: actual %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference: earliest raster index holding the minimum, runner-up is the second element of the sorted window
   function automatic exp_t modelSearch();
      exp_t        e;
      int          bi;
      logic [11:0] srt[$];
      bi = 0;
      for (int i = 1; i < NPOS; i++) begin
         if (scores[i] < scores[bi]) bi = i;
      end
      srt = {};
      for (int i = 0; i < NPOS; i++) srt.push_back(scores[i]);
      srt.sort();
      e.sad    = scores[bi];
      e.x      = bi % COLS;
      e.y      = bi / COLS;
      e.second = srt[1];
`ifdef MATCH_COMPARATOR_SECOND_BEST_EN
      e.m      = (int'(e.sad) <= int'(THRESH)) && ((int'(srt[1]) - int'(srt[0])) >= 16);
`else
      e.m      = (int'(e.sad) <= int'(THRESH));
`endif
      e.done_cyc = 0;
      return e;
   endfunction

   task automatic checkReset(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_best_sad"}, 32'(best_sad), 32'hFFF);
      checkOutput({tag, "_best_x"}, 32'(best_x), 32'd0);
      checkOutput({tag, "_best_y"}, 32'(best_y), 32'd0);
      checkOutput({tag, "_match"}, 32'(match), 32'd0);
`ifdef MATCH_COMPARATOR_SECOND_BEST_EN
      checkOutput({tag, "_second_sad"}, 32'(second_sad), 32'hFFF);
`endif
   endtask

   // Presents the whole window with gaps of gmin..gmax idle cycles before each sample
   task automatic feedWindow(input int gmin, input int gmax);
      for (int i = 0; i < NPOS; i++) begin
         ena = 1'b0;
         repeat ($urandom_range(gmax, gmin)) @(negedge clk);
         ena    = 1'b1;
         d_in   = scores[i];
         last_n = cyc + 1;
         @(negedge clk);
      end
      ena = 1'b0;
   endtask

   // restart_after > 0: that many zero samples, then start+ena together before the real window
   task automatic applyStimulus(input int gmin, input int gmax, input int restart_after);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      ena   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      if (restart_after > 0) begin
         for (int i = 0; i < restart_after; i++) begin
            ena  = 1'b1;
            d_in = 12'd0;
            @(negedge clk);
         end
         start = 1'b1;
         ena   = 1'b1;
         d_in  = 12'd0;
         @(negedge clk);
         start = 1'b0;
         ena   = 1'b0;
         checkOutput("busy_after_restart", 32'(busy), 32'd1);
      end
      feedWindow(gmin, gmax);
      checkOutput("busy_after_last", 32'(busy), 32'd0);
      e          = modelSearch();
      e.done_cyc = last_n + 1;
      last_sad   = e.sad;
      last_match = e.m;
      exp_q.push_back(e);
      dones_expected++;
   endtask

   task automatic waitIdle();
      int budget;
      budget = 100;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL done_timeout: actual no done, expected done within 100 cycles");
         exp_q = {};
      end
      repeat (2) @(negedge clk);
      checkOutput("hold_best_sad", 32'(best_sad), 32'(last_sad));
      checkOutput("hold_match", 32'(match), 32'(last_match));
   endtask

   // Monitor: every done pulse retires one scoreboard entry
   initial begin : monitor
      exp_t e;
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_done) checkOutput("done_pulse_width", 32'(done), 32'd0);
         if (done === 1'b1) begin
            dones_seen++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("[TB] FAIL unexpected_done: actual done=1, expected no pulse (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               checkOutput("done_cycle", 32'(cyc), 32'(e.done_cyc));
               checkOutput("best_sad", 32'(best_sad), 32'(e.sad));
               checkOutput("best_x", 32'(best_x), 32'(e.x));
               checkOutput("best_y", 32'(best_y), 32'(e.y));
               checkOutput("match", 32'(match), 32'(e.m));
`ifdef MATCH_COMPARATOR_SECOND_BEST_EN
               checkOutput("second_sad", 32'(second_sad), 32'(e.second));
`endif
            end
         end
         prev_done = (done === 1'b1);
      end
   end

   initial begin : stimulus
      n_cmp          = 0;
      n_fail         = 0;
      dones_seen     = 0;
      dones_expected = 0;
      last_n         = 0;
      last_sad       = 12'hFFF;
      last_match     = 1'b0;
      rst            = 1'b1;
      start          = 1'b0;
      ena            = 1'b0;
      d_in           = 12'd0;
      repeat (3) @(negedge clk);
      checkReset("reset");
      rst = 1'b0;

      $display("[TB] directed window, no gaps");
      scores = '{12'd500, 12'd300, 12'd90, 12'd90, 12'd700, 12'd80, 12'd200, 12'd999};
      applyStimulus(0, 0, 0);
      waitIdle();

      $display("[TB] all scores at 4000");
      scores = '{12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000};
      applyStimulus(0, 0, 0);
      waitIdle();

      $display("[TB] tie at (2,0) and (3,0)");
      scores = '{12'd500, 12'd300, 12'd90, 12'd90, 12'd700, 12'd800, 12'd200, 12'd999};
      applyStimulus(0, 0, 0);
      waitIdle();

      $display("[TB] directed window with 1-3 cycle gaps");
      scores = '{12'd500, 12'd300, 12'd90, 12'd90, 12'd700, 12'd80, 12'd200, 12'd999};
      applyStimulus(1, 3, 0);
      waitIdle();

      $display("[TB] reset after 5 samples");
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ena  = 1'b1;
         d_in = 12'd10;
         @(negedge clk);
      end
      ena = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checkReset("abort");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      scores = '{12'd40, 12'd300, 12'd90, 12'd20, 12'd700, 12'd80, 12'd200, 12'd999};
      applyStimulus(0, 0, 0);
      waitIdle();

      $display("[TB] start with ena on the 3rd sample");
      scores = '{12'd500, 12'd300, 12'd90, 12'd95, 12'd700, 12'd85, 12'd200, 12'd999};
      applyStimulus(0, 0, 2);
      waitIdle();

      $display("[TB] runner-up margin windows");
      scores = '{12'd50, 12'd60, 12'd900, 12'd900, 12'd900, 12'd900, 12'd900, 12'd900};
      applyStimulus(0, 0, 0);
      waitIdle();
      scores = '{12'd50, 12'd70, 12'd900, 12'd900, 12'd900, 12'd900, 12'd900, 12'd900};
      applyStimulus(0, 0, 0);
      waitIdle();

      $display("[TB] random windows");
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < NPOS; i++) begin
            if (r % 2 == 0) scores[i] = 12'($urandom_range(4095, 0));
            else            scores[i] = 12'($urandom_range(120, 40));
         end
         applyStimulus(0, 2, 0);
         waitIdle();
      end

      repeat (5) @(negedge clk);
      checkOutput("done_count", 32'(dones_seen), 32'(dones_expected));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
